uart_tx: RTL and testbench
==========================

# uart_tx

8N1 UART transmitter: the transmit end of the 115200 bps serial link whose receive side samples at 16× baud. Accepts one byte per valid/ready handshake from the host logic, serialises it LSB-first on `txd` with one start and one stop bit, and runs on the 50 MHz system clock using an internal bit-period counter. No external divided clock is used.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `DIV`, (CLK_HZ + BAUD/2)/BAUD = 434: cycles per bit (derived, not overridden); legal range 2..65536.

- `clk50`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send; sampled on the accept edge only.
- `tx_valid`  in  1  host has a byte.
- `tx_ready`  out  1  block can accept; byte accepted on an edge where `tx_valid && tx_ready`.
- `txd`  out  1  serial line, idle high.
- `tx_busy`  out  1  frame in progress (inverse of `tx_ready` outside reset).

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE: `tx_ready`=1, `txd`=1. On accept edge: `shreg`←`tx_data`, `baud_cnt`←0, `bit_cnt`←0, `txd`←0, `tx_ready`←0, `tx_busy`←1, → START.
- `baud_cnt` (16 bit) increments every cycle outside IDLE; bit end = `baud_cnt == DIV-1`, at which `baud_cnt`←0.
- START, bit end: `txd`←`shreg[0]`, `shreg`←`shreg>>1`, → DATA.
- DATA, bit end: if `bit_cnt==7`: `txd`←1, → STOP; else `txd`←`shreg[0]`, shift, `bit_cnt`++.
- STOP, bit end: → IDLE, `tx_ready`←1, `tx_busy`←0; `txd` stays 1.
- `tx_valid` outside IDLE is ignored; `tx_data` changes mid-frame do not affect the line.
- `tx_valid` without `tx_ready`: host must hold `tx_valid` and `tx_data` until accepted.

## Timing
- Reset (any state, including mid-frame): on the edge with `rst`=1: `txd`←1, `tx_ready`←0, `tx_busy`←0, state←IDLE, counters←0, `shreg`←0. First edge with `rst`=0 sets `tx_ready`←1; earliest accept is the following edge. A truncated frame is simply abandoned (line returns high).
- Accept at edge N: `txd` low for cycles N..N+DIV-1 (start bit), bit k (k=0..7) on `txd` from edge N+(k+1)·DIV for DIV cycles, stop bit from N+9·DIV.
- `tx_ready` rises at edge N+10·DIV; next accept no earlier than N+10·DIV+1. Back-to-back frames therefore repeat every 10·DIV+1 cycles (stop bit effectively DIV+1 cycles).
- All outputs registered; no combinational path from inputs to outputs.
- Baud error at defaults: 50e6/434 = 115207 bps (+0.006%).

## Structure
- Shared package `uart_pkg`: state encoding (IDLE/START/DATA/STOP), `DATA_BITS`=8, `baud_div(clk_hz, baud)` rounding function, also used by the receiver's oversample divider.
- One sub-module natural: `uart_baud_cnt` — restartable counter with `restart`, `run` inputs and one-cycle `bit_end` strobe at count DIV-1. The rest (FSM, shift register, handshake) stays in `uart_tx`.

## Test plan
Benches use `CLK_HZ`=1_000_000, `BAUD`=100_000 (DIV=10) unless stated.
- Reset then single byte 0x55 accepted at edge N -> `txd` = 0,1,0,1,0,1,0,1,0,1 each 10 cycles starting N, `tx_ready` back to 1 at N+100.
- Byte 0xA3 with `tx_valid` held high continuously for 3 bytes (0xA3, 0x00, 0xFF) -> frames start every 101 cycles, data LSB-first; a bench UART receiver model decodes 0xA3, 0x00, 0xFF with zero framing errors.
- `tx_data` toggled and `tx_valid` pulsed during frame of 0x3C -> line carries only 0x3C; no second frame starts.
- `rst` asserted at cycle 45 of a frame of 0x0F -> `txd`=1 and `tx_busy`=0 on that edge, `tx_ready`=1 one edge after `rst` drops, next byte 0x81 transmits cleanly.
- Default parameters (DIV=434), byte 0x7E -> each bit exactly 434 cycles, total busy time 4340 cycles.
- `rst` held high with `tx_valid`=1 for 5 cycles -> no accept, `txd` stays 1, `tx_ready` stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and the
// clock-to-baud divider rounding used by both transmit and receive sides.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

   localparam int DATA_BITS = 8;
   localparam int BIT_CNT_W = $clog2(DATA_BITS);

   // Nearest-integer divider; the receiver reuses this with baud*16.
   function automatic int baud_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Restartable bit-period counter; bit_end strobes for one cycle when the
// count reaches DIV-1, and the counter wraps to zero on that same edge.
module uart_baud_cnt #(
   parameter int DIV = 434
) (
   input  logic clk50,
   input  logic rst,
   input  logic restart,
   input  logic run,
   output logic bit_end
);

   localparam logic [15:0] CNT_LAST = 16'(DIV - 1);

   logic [15:0] baud_cnt;

   assign bit_end = run && (baud_cnt == CNT_LAST);

   always_ff @(posedge clk50) begin
      if (rst || restart) begin
         baud_cnt <= '0;
      end else if (run) begin
         baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: valid/ready byte intake, LSB-first serialisation on
// txd with one start and one stop bit, bit timing from an internal divider.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | line high, ready for a byte
//   ST_START | start bit (txd low) for one bit period
//   ST_DATA  | shifting out data bits, LSB first
//   ST_STOP  | stop bit (txd high) for one bit period
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115_200
) (
   input  logic                 clk50,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_busy
);

   localparam int                     DIV      = baud_div(CLK_HZ, BAUD);
   localparam logic [BIT_CNT_W-1:0]   BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

   tx_state_e              state;
   logic [DATA_BITS-1:0]   shreg;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic                   accept;
   logic                   bit_end;

   // tx_ready is only ever high in ST_IDLE, so it alone qualifies the accept.
   assign accept = tx_valid && tx_ready;

   uart_baud_cnt #(
      .DIV (DIV)
   ) u_baud_cnt (
      .clk50   (clk50),
      .rst     (rst),
      .restart (accept),
      .run     (state != ST_IDLE),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk50) begin
      if (rst) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         txd      <= 1'b1;
         tx_ready <= 1'b0;
         tx_busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               txd <= 1'b1;
               if (accept) begin
                  shreg    <= tx_data;
                  bit_cnt  <= '0;
                  txd      <= 1'b0;
                  tx_ready <= 1'b0;
                  tx_busy  <= 1'b1;
                  state    <= ST_START;
               end else begin
                  tx_ready <= 1'b1;
                  tx_busy  <= 1'b0;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  txd   <= shreg[0];
                  shreg <= shreg >> 1;
                  state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == BIT_LAST) begin
                     txd   <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     txd     <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                  end
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  tx_ready <= 1'b1;
                  tx_busy  <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed steps on a DIV=10 instance decoded by a UART
// receiver model fed from an expected-byte queue, plus a default-rate instance.
module tb_uart_tx;

   localparam int DIV_T = 10;
   localparam int DIV_D = 434;

   logic       clk50 = 1'b0;
   logic       rst, tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready, txd, tx_busy;

   logic       rst_d, tx_valid_d;
   logic [7:0] tx_data_d;
   logic       tx_ready_d, txd_d, tx_busy_d;

   int         vectors     = 0;
   int         miscompares = 0;
   int         rx_frames   = 0;
   int         cyc         = 0;
   logic [7:0] rx_q[$];
   logic [7:0] burst[0:2];
   int         starts[0:2];

   always #5 clk50 = ~clk50;
   always @(posedge clk50) cyc <= cyc + 1;

   uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
      .clk50    (clk50),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .txd      (txd),
      .tx_busy  (tx_busy)
   );

   uart_tx dut_d (
      .clk50    (clk50),
      .rst      (rst_d),
      .tx_data  (tx_data_d),
      .tx_valid (tx_valid_d),
      .tx_ready (tx_ready_d),
      .txd      (txd_d),
      .tx_busy  (tx_busy_d)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   // Line level in bit slot i of a frame: 0 start, 1..8 data LSB first, 9 stop.
   function automatic logic frame_bit(input logic [7:0] d, input int i);
      if (i == 0) return 1'b0;
      if (i >= 9) return 1'b1;
      return d[i-1];
   endfunction

   task automatic rx_wait(input int n, output bit ab);
      ab = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk50);
         if (rst !== 1'b0) ab = 1'b1;
      end
   endtask

   // Receiver model: detects the falling edge, samples mid-bit, aborts on reset.
   initial begin : rx_model
      logic       prev;
      logic [7:0] d;
      logic       s0, sp;
      bit         ab;
      prev = 1'b1;
      d    = '0;
      forever begin
         @(negedge clk50);
         if (rst !== 1'b0) begin
            prev = 1'b1;
         end else if (prev && txd === 1'b0) begin
            rx_wait(DIV_T / 2, ab);
            s0 = txd;
            for (int i = 0; i < 8; i++) begin
               if (!ab) begin
                  rx_wait(DIV_T, ab);
                  d[i] = txd;
               end
            end
            if (!ab) rx_wait(DIV_T, ab);
            sp = txd;
            if (!ab) begin
               rx_frames++;
               check("rx_start_bit", 32'(s0), 32'd0);
               check("rx_stop_bit", 32'(sp), 32'd1);
               check("rx_frame_expected", 32'(rx_q.size() != 0), 32'd1);
               if (rx_q.size() != 0) check("rx_data", 32'(d), 32'(rx_q.pop_front()));
            end
            prev = 1'b1;
         end else begin
            prev = txd;
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input bit perturb);
      int n = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check("send_ready_wait", 32'(n < 200), 32'd1);
      tick();
      tx_valid = 1'b0;
      rx_q.push_back(b);
      check("accept_ready_low", 32'(tx_ready), 32'd0);
      check("accept_busy_high", 32'(tx_busy), 32'd1);
      for (int c = 0; c < 10 * DIV_T; c++) begin
         check("frame_txd", 32'(txd), 32'(frame_bit(b, c / DIV_T)));
         if (perturb) begin
            tx_data  = 8'($urandom);
            tx_valid = (c % 7 == 3);
         end
         tick();
      end
      tx_valid = 1'b0;
      check("frame_end_ready", 32'(tx_ready), 32'd1);
      check("frame_end_busy", 32'(tx_busy), 32'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares",
               vectors, miscompares);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int errs;
      burst[0] = 8'hA3;
      burst[1] = 8'h00;
      burst[2] = 8'hFF;

      // Reset held with tx_valid high: nothing may be accepted.
      rst        = 1'b1;
      tx_valid   = 1'b1;
      tx_data    = 8'hEE;
      rst_d      = 1'b1;
      tx_valid_d = 1'b0;
      tx_data_d  = 8'h00;
      repeat (5) begin
         tick();
         check("rst_txd", 32'(txd), 32'd1);
         check("rst_ready", 32'(tx_ready), 32'd0);
         check("rst_busy", 32'(tx_busy), 32'd0);
      end
      rst      = 1'b0;
      rst_d    = 1'b0;
      tx_valid = 1'b0;
      tick();
      check("post_rst_ready", 32'(tx_ready), 32'd1);
      check("post_rst_txd", 32'(txd), 32'd1);
      check("post_rst_busy", 32'(tx_busy), 32'd0);

      send_frame(8'h55, 1'b0);

      // Valid held high across three bytes: frames every 10*DIV+1 cycles.
      tx_valid = 1'b1;
      for (int b = 0; b < 3; b++) begin
         tx_data = burst[b];
         n = 0;
         while (tx_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
         end
         check("burst_ready_wait", 32'(n < 300), 32'd1);
         tick();
         starts[b] = cyc;
         rx_q.push_back(burst[b]);
         check("burst_accept_busy", 32'(tx_busy), 32'd1);
         check("burst_accept_txd", 32'(txd), 32'd0);
      end
      tx_valid = 1'b0;
      tx_data  = 8'h5A;
      check("burst_period_1", 32'(starts[1] - starts[0]), 32'(10 * DIV_T + 1));
      check("burst_period_2", 32'(starts[2] - starts[1]), 32'(10 * DIV_T + 1));
      n = 0;
      while (tx_busy !== 1'b0 && n < 300) begin
         tick();
         n++;
      end
      check("burst_done_wait", 32'(n < 300), 32'd1);
      check("burst_rx_frames", 32'(rx_frames), 32'd4);

      // Input churn mid-frame must not disturb the line or start a new frame.
      send_frame(8'h3C, 1'b1);
      repeat (20) begin
         tick();
         check("churn_idle_busy", 32'(tx_busy), 32'd0);
         check("churn_idle_txd", 32'(txd), 32'd1);
      end

      // Reset at cycle 45 of a 0x0F frame.
      tx_data  = 8'h0F;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      check("trunc_accept_busy", 32'(tx_busy), 32'd1);
      repeat (44) tick();
      check("trunc_bit_pre_rst", 32'(txd), 32'(frame_bit(8'h0F, 4)));
      rst = 1'b1;
      tick();
      check("trunc_rst_txd", 32'(txd), 32'd1);
      check("trunc_rst_busy", 32'(tx_busy), 32'd0);
      check("trunc_rst_ready", 32'(tx_ready), 32'd0);
      rst = 1'b0;
      tick();
      check("trunc_release_ready", 32'(tx_ready), 32'd1);
      check("trunc_release_txd", 32'(txd), 32'd1);
      send_frame(8'h81, 1'b0);
      repeat (5) tick();
      check("rx_total_frames", 32'(rx_frames), 32'd6);
      check("rx_queue_drained", 32'(rx_q.size()), 32'd0);

      // Default rate: each bit 434 cycles, busy for 4340 cycles.
      tx_data_d  = 8'h7E;
      tx_valid_d = 1'b1;
      n = 0;
      while (tx_ready_d !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check("def_ready", 32'(tx_ready_d), 32'd1);
      tick();
      tx_valid_d = 1'b0;
      tx_data_d  = 8'h00;
      check("def_accept_busy", 32'(tx_busy_d), 32'd1);
      n    = 0;
      errs = 0;
      while (tx_busy_d === 1'b1 && n < 5000) begin
         if (txd_d !== frame_bit(8'h7E, n / DIV_D)) errs++;
         tick();
         n++;
      end
      check("def_bit_errors", 32'(errs), 32'd0);
      check("def_busy_cycles", 32'(n), 32'(10 * DIV_D));
      check("def_end_ready", 32'(tx_ready_d), 32'd1);
      check("def_end_txd", 32'(txd_d), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
